// File: rtl/theta_stim_pkg.sv
// Shared types, default parameters and helpers for the theta-locked stimulus sequencer.
// Amplitudes and thresholds are Q4.14 signed values.
package theta_stim_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT_PEAK,
    ST_STIM_HOLD,
    ST_WAIT_FALL,
    ST_WAIT_TROUGH,
    ST_SETTLE,
    ST_CUE,
    ST_CUE_HOLD,
    ST_WAIT_PEAK2,
    ST_POST,
    ST_FINISH
  } state_e;

  typedef enum logic {
    MODE_TRAIN  = 1'b0,
    MODE_RECALL = 1'b1
  } mode_e;

  localparam int unsigned TICK_W = 16;
  localparam int unsigned PAT_W  = 6;

  localparam int          DEF_WIDTH         = 18;
  localparam int          DEF_FRAC          = 14;
  localparam int          DEF_PEAK_THRESH   = 12288;
  localparam int          DEF_TROUGH_THRESH = -12288;
  localparam int          DEF_FALL_MARGIN   = 2000;
  localparam int          DEF_TRAIN_AMP     = 12000;
  localparam int          DEF_CUE_AMP       = -8000;
  localparam int unsigned DEF_STIM_HOLD     = 30;
  localparam int unsigned DEF_SETTLE        = 50;
  localparam int unsigned DEF_CUE_SAMPLE    = 10;
  localparam int unsigned DEF_CUE_HOLD      = 50;
  localparam int unsigned DEF_POST          = 20;
  localparam int unsigned DEF_TIMEOUT       = 4000;

  // Sequence parameters captured when a start is accepted.
  typedef struct packed {
    mode_e              mode;
    logic [PAT_W-1:0]   pattern;
    logic [PAT_W-1:0]   expected;
  } job_t;

  // Number of bit positions where the recalled pattern agrees with the target.
  function automatic logic [2:0] match_count(input logic [PAT_W-1:0] a,
                                             input logic [PAT_W-1:0] b);
    logic [2:0] n;
    n = '0;
    for (int unsigned i = 0; i < PAT_W; i++) begin
      n = n + {2'b00, ~(a[i] ^ b[i])};
    end
    return n;
  endfunction

endpackage

// File: rtl/tick_timer.sv
// Loadable down-counter advanced by the update strobe; expire_o flags the tick
// on which the loaded count runs out.
module tick_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_en_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expire_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (clk_en_i && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  // Combinational so the owner can act on the expiring tick without a cycle of lag.
  assign expire_o = clk_en_i && (count_q == W'(1));

endmodule

// File: rtl/theta_stim_sequencer.sv
// Phase-locks encode stimuli to theta peaks and recall cues to theta troughs,
// counts sampled CA3 learning events and scores recalled patterns.
module theta_stim_sequencer
  import theta_stim_pkg::*;
#(
  parameter int          WIDTH         = DEF_WIDTH,
  parameter int          FRAC          = DEF_FRAC,
  parameter int          PEAK_THRESH   = DEF_PEAK_THRESH,
  parameter int          TROUGH_THRESH = DEF_TROUGH_THRESH,
  parameter int          FALL_MARGIN   = DEF_FALL_MARGIN,
  parameter int          TRAIN_AMP     = DEF_TRAIN_AMP,
  parameter int          CUE_AMP       = DEF_CUE_AMP,
  parameter int unsigned STIM_HOLD     = DEF_STIM_HOLD,
  parameter int unsigned SETTLE        = DEF_SETTLE,
  parameter int unsigned CUE_SAMPLE    = DEF_CUE_SAMPLE,
  parameter int unsigned CUE_HOLD      = DEF_CUE_HOLD,
  parameter int unsigned POST          = DEF_POST,
  parameter int unsigned TIMEOUT       = DEF_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic signed [WIDTH-1:0] theta_x,
  input  logic                    start,
  input  logic                    mode,
  input  logic [PAT_W-1:0]        pattern,
  input  logic [PAT_W-1:0]        expected,
  input  logic [3:0]              reps,
  input  logic                    abort,
  input  logic                    ca3_learning,
  input  logic                    ca3_recalling,
  input  logic [PAT_W-1:0]        ca3_phase_pattern,
  output logic signed [WIDTH-1:0] sensory_input,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout_err,
  output logic [3:0]              learn_count,
  output logic                    recall_hit,
  output logic [2:0]              accuracy
);

  if ((FRAC >= WIDTH) || (STIM_HOLD == 0) || (SETTLE == 0) || (CUE_SAMPLE == 0) ||
      (CUE_HOLD == 0) || (POST == 0) || (TIMEOUT == 0)) begin : g_bad_params
    $error("theta_stim_sequencer: invalid parameter set");
  end

  localparam logic signed [WIDTH-1:0] PEAK_LVL   = WIDTH'(PEAK_THRESH);
  localparam logic signed [WIDTH-1:0] FALL_LVL   = WIDTH'(PEAK_THRESH - FALL_MARGIN);
  localparam logic signed [WIDTH-1:0] TROUGH_LVL = WIDTH'(TROUGH_THRESH);
  localparam logic signed [WIDTH-1:0] TRAIN_LVL  = WIDTH'(TRAIN_AMP);
  localparam logic signed [WIDTH-1:0] CUE_LVL    = WIDTH'(CUE_AMP);

  localparam logic [TICK_W-1:0] T_HOLD   = TICK_W'(STIM_HOLD);
  localparam logic [TICK_W-1:0] T_SETTLE = TICK_W'(SETTLE);
  localparam logic [TICK_W-1:0] T_CUE    = TICK_W'(CUE_SAMPLE);
  localparam logic [TICK_W-1:0] T_CUEH   = TICK_W'(CUE_HOLD);
  localparam logic [TICK_W-1:0] T_POST   = TICK_W'(POST);
  localparam logic [TICK_W-1:0] T_TOUT   = TICK_W'(TIMEOUT);

  state_e                  state_q, state_d;
  job_t                    job_q, job_d;
  logic [3:0]              rep_q, rep_d;
  logic signed [WIDTH-1:0] sens_q, sens_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    tout_q, tout_d;
  logic [3:0]              learn_q, learn_d;
  logic                    hit_q, hit_d;
  logic [2:0]              acc_q, acc_d;

  logic                    tmr_load;
  logic [TICK_W-1:0]       tmr_val;
  logic                    tmr_exp;
  logic signed [WIDTH-1:0] amp;

  logic at_peak, below_fall, at_trough;
  assign at_peak    = (theta_x >= PEAK_LVL);
  assign below_fall = (theta_x <= FALL_LVL);
  assign at_trough  = (theta_x <= TROUGH_LVL);

  tick_timer #(
    .W (TICK_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clk_en_i   (clk_en),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expire_o   (tmr_exp)
  );

  always_comb begin
    amp = '0;
    if (job_q.pattern != '0) begin
      amp = (job_q.mode == MODE_RECALL) ? CUE_LVL : TRAIN_LVL;
    end
  end

  always_comb begin
    state_d  = state_q;
    job_d    = job_q;
    rep_d    = rep_q;
    sens_d   = sens_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    tout_d   = tout_q;
    learn_d  = learn_q;
    hit_d    = hit_q;
    acc_d    = acc_q;
    tmr_load = 1'b0;
    tmr_val  = T_TOUT;

    if (abort) begin
      state_d = ST_IDLE;
      sens_d  = '0;
      busy_d  = 1'b0;
    end else if (state_q == ST_IDLE) begin
      if (start) begin
        job_d    = '{mode: mode_e'(mode), pattern: pattern, expected: expected};
        rep_d    = reps;
        busy_d   = 1'b1;
        tout_d   = 1'b0;
        learn_d  = '0;
        hit_d    = 1'b0;
        acc_d    = '0;
        tmr_load = 1'b1;
        if (mode_e'(mode) == MODE_RECALL) state_d = ST_WAIT_TROUGH;
        else if (reps == 4'd0)            state_d = ST_FINISH;
        else                              state_d = ST_WAIT_PEAK;
      end
    end else if (state_q == ST_FINISH) begin
      done_d  = 1'b1;
      busy_d  = 1'b0;
      sens_d  = '0;
      state_d = ST_IDLE;
    end else if (clk_en) begin
      // Threshold checks take priority over timeout so a crossing on the last
      // permitted tick still advances normally.
      case (state_q)
        ST_WAIT_PEAK: begin
          if (at_peak) begin
            sens_d   = amp;
            state_d  = ST_STIM_HOLD;
            tmr_load = 1'b1;
            tmr_val  = T_HOLD;
          end else if (tmr_exp) begin
            tout_d  = 1'b1;
            sens_d  = '0;
            state_d = ST_FINISH;
          end
        end
        ST_STIM_HOLD: begin
          if (tmr_exp) begin
            if (ca3_learning && (learn_q != 4'hF)) learn_d = learn_q + 4'd1;
            state_d  = ST_WAIT_FALL;
            tmr_load = 1'b1;
          end
        end
        ST_WAIT_FALL: begin
          if (below_fall) begin
            sens_d   = '0;
            state_d  = ST_WAIT_TROUGH;
            tmr_load = 1'b1;
          end else if (tmr_exp) begin
            tout_d  = 1'b1;
            sens_d  = '0;
            state_d = ST_FINISH;
          end
        end
        ST_WAIT_TROUGH: begin
          if (at_trough) begin
            tmr_load = 1'b1;
            if (job_q.mode == MODE_RECALL) begin
              sens_d  = amp;
              state_d = ST_CUE;
              tmr_val = T_CUE;
            end else begin
              state_d = ST_SETTLE;
              tmr_val = T_SETTLE;
            end
          end else if (tmr_exp) begin
            tout_d  = 1'b1;
            sens_d  = '0;
            state_d = ST_FINISH;
          end
        end
        ST_SETTLE: begin
          if (tmr_exp) begin
            rep_d = rep_q - 4'd1;
            if (rep_q == 4'd1) begin
              state_d = ST_FINISH;
            end else begin
              state_d  = ST_WAIT_PEAK;
              tmr_load = 1'b1;
            end
          end
        end
        ST_CUE: begin
          if (tmr_exp) begin
            hit_d    = ca3_recalling;
            state_d  = ST_CUE_HOLD;
            tmr_load = 1'b1;
            tmr_val  = T_CUEH;
          end
        end
        ST_CUE_HOLD: begin
          if (tmr_exp) begin
            acc_d    = match_count(ca3_phase_pattern, job_q.expected);
            sens_d   = '0;
            state_d  = ST_WAIT_PEAK2;
            tmr_load = 1'b1;
          end
        end
        ST_WAIT_PEAK2: begin
          if (at_peak) begin
            state_d  = ST_POST;
            tmr_load = 1'b1;
            tmr_val  = T_POST;
          end else if (tmr_exp) begin
            tout_d  = 1'b1;
            sens_d  = '0;
            state_d = ST_FINISH;
          end
        end
        ST_POST: begin
          if (tmr_exp) state_d = ST_FINISH;
        end
        default: begin
          state_d = ST_IDLE;
          sens_d  = '0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      job_q   <= '0;
      rep_q   <= '0;
      sens_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tout_q  <= 1'b0;
      learn_q <= '0;
      hit_q   <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      job_q   <= job_d;
      rep_q   <= rep_d;
      sens_q  <= sens_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tout_q  <= tout_d;
      learn_q <= learn_d;
      hit_q   <= hit_d;
      acc_q   <= acc_d;
    end
  end

  assign sensory_input = sens_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign timeout_err   = tout_q;
  assign learn_count   = learn_q;
  assign recall_hit    = hit_q;
  assign accuracy      = acc_q;

endmodule

// File: doc/theta_stim_sequencer.md
Name: theta_stim_sequencer

Overview:
Hardware stimulus sequencer that sits directly upstream of phi_n_neural_processor and drives its sensory_input. It phase-locks encode stimuli to thalamic theta peaks and recall cues to theta troughs. It counts CA3 learning events and scores recalled patterns, so on-board learning experiments run without a host testbench. All timing is measured in 4 kHz update ticks (clk_en).

Parameters:
WIDTH, 18, sample width (signed, Q4.14)
FRAC, 14, fractional bits
PEAK_THRESH, 12288, theta peak threshold
TROUGH_THRESH, -12288, theta trough threshold
FALL_MARGIN, 2000, stimulus released once theta_x <= PEAK_THRESH-FALL_MARGIN
TRAIN_AMP, 12000, encode amplitude
CUE_AMP, -8000, recall cue amplitude
STIM_HOLD, 30, ticks held after peak before learning sample
SETTLE, 50, ticks after trough between reps
CUE_SAMPLE, 10, ticks into cue before recalling sample
CUE_HOLD, 50, further ticks before pattern scoring
POST, 20, ticks after returning peak before done
TIMEOUT, 4000, max ticks in any theta-wait state

Ports:
clk  in  1  system clock (125 MHz)
rst  in  1  synchronous active-high reset
clk_en  in  1  4 kHz update strobe, one clk wide
theta_x  in  WIDTH  signed thalamic theta sample
start  in  1  launch a sequence (ignored while busy)
mode  in  1  0=train, 1=recall; latched at start
pattern  in  6  train pattern / recall cue; latched at start
expected  in  6  recall target; latched at start
reps  in  4  train repetitions; latched at start
abort  in  1  terminate sequence
ca3_learning  in  1  CA3 learning flag
ca3_recalling  in  1  CA3 recall flag
ca3_phase_pattern  in  6  CA3 recalled pattern
sensory_input  out  WIDTH  signed stimulus to processor
busy  out  1  sequence in progress
done  out  1  one-clk pulse on normal completion
timeout_err  out  1  sticky; set on wait timeout, cleared by next accepted start
learn_count  out  4  saturating count of sampled learning events
recall_hit  out  1  ca3_recalling seen at cue sample
accuracy  out  3  matching bits 0..6 from last recall

Behaviour:
- Reset: all outputs 0; state IDLE; latched inputs cleared.
- start accepted in IDLE only. busy=1 on the next clk. accuracy, recall_hit, learn_count and timeout_err are cleared on acceptance.
- State transitions are evaluated only on clk_en=1 cycles, except start, abort and rst, which act on any clk.
- Amplitude: TRAIN_AMP or CUE_AMP when the latched pattern is nonzero; 0 when pattern==0. Timing is unchanged for pattern==0.
- Train FSM:
  - IDLE -> WAIT_PEAK. If reps==0, go straight to FINISH: done pulses 1 clk later and no stimulus is driven.
  - WAIT_PEAK: advance when theta_x >= PEAK_THRESH. sensory_input=amp from the same clk.
  - STIM_HOLD: STIM_HOLD ticks. On the last tick, sample ca3_learning; if 1, learn_count+1, saturating at 15.
  - WAIT_FALL: when theta_x <= PEAK_THRESH-FALL_MARGIN, sensory_input=0.
  - WAIT_TROUGH: advance when theta_x <= TROUGH_THRESH.
  - SETTLE: SETTLE ticks. Then decrement the rep counter; nonzero -> WAIT_PEAK, zero -> FINISH.
- Recall FSM:
  - WAIT_TROUGH: sensory_input=amp on entry to CUE.
  - CUE: CUE_SAMPLE ticks, then latch recall_hit=ca3_recalling.
  - CUE_HOLD: CUE_HOLD ticks, then accuracy=popcount(~(ca3_phase_pattern^expected)) and sensory_input=0.
  - WAIT_PEAK2 -> POST: POST ticks -> FINISH.
- FINISH: done=1 for exactly one clk, busy=0, return to IDLE. Result outputs hold until the next start.
- Comparisons are signed at full WIDTH; no arithmetic on theta_x other than the compile-time PEAK_THRESH-FALL_MARGIN.
- Timeout: each theta-wait state (WAIT_PEAK, WAIT_FALL, WAIT_TROUGH, WAIT_PEAK2) counts ticks from entry. On reaching TIMEOUT: timeout_err=1, sensory_input=0, go to FINISH (done still pulses).
- Threshold already satisfied on entry advances on the first clk_en, with no spurious extra tick.
- abort, or rst mid-sequence: next clk sensory_input=0, busy=0, IDLE, no done.
  - abort preserves result outputs.
  - rst clears everything.
- abort and start in the same clk: abort wins and start is dropped.
- Tick counters reload on state entry and are 16 bits wide. Parameters must be at least 1.

Decomposition:
- Package theta_stim_pkg: FSM state enum, mode encodings, default thresholds and amplitudes.
- Sub-module tick_timer: a loadable down-counter gated by clk_en, with an expiry flag. It is shared by the hold counts and the timeout.

Test Plan:
- Synthetic theta sine (±16000, period 40 ticks), train pattern=101010, reps=3, ca3_learning tied 1:
  - sensory_input=12000 exactly in three windows, each starting at a peak crossing.
  - learn_count=3, then a done pulse.
- Recall, cue=100000, expected=101010, ca3_phase_pattern forced 101000, ca3_recalling=1:
  - sensory_input=-8000 from the trough for 60 ticks.
  - recall_hit=1, accuracy=5.
- theta_x held at 0, start train:
  - after 4000 ticks, timeout_err=1, sensory_input=0, done pulses.
- abort asserted during STIM_HOLD:
  - next clk sensory_input=0, busy=0, no done.
  - learn_count unchanged.
- reps=0:
  - done 1 clk after busy, sensory_input never nonzero.
- pattern=000000, train reps=2:
  - full timing runs and done pulses.
  - sensory_input stays 0 throughout.
